// File: rtl/sap_ram16x8_if.sv
// Signal bundle between the SAP-1 front panel/controller side and the 16x8 RAM.
// The master drives address, mode, switches, write button and bus enable; the slave returns bus data and write status.
interface sap_ram16x8_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] addr;
    logic              prog;
    logic [DATA_W-1:0] sw_data;
    logic              wr_btn;
    logic              ce_n;
    logic [DATA_W-1:0] bus_out;
    logic              bus_oe;
    logic              wr_busy;
    logic              wr_done;

    modport master (
        output addr, prog, sw_data, wr_btn, ce_n,
        input  bus_out, bus_oe, wr_busy, wr_done
    );

    modport slave (
        input  addr, prog, sw_data, wr_btn, ce_n,
        output bus_out, bus_oe, wr_busy, wr_done
    );
endinterface

// File: rtl/sap_ram16x8.sv
// SAP-1 16x8 program/data RAM: debounced panel writes in program mode, W-bus reads in run mode (SAP_RAM_CLEAR_EN: clr zeroes memory).
// Latency: read 1 cycle; write lands DEBOUNCE_CYC+1 edges after first high wr_btn sample, wr_done the cycle after.
// Backpressure: none; a new press is ignored until the release wait completes (wr_busy).
module sap_ram16x8 #(
    parameter int ADDR_W       = 4,
    parameter int DATA_W       = 8,
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic          clk,
    input  logic          clr,
    sap_ram16x8_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, DEBOUNCE, WRITE, RELEASE} state_t;

    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYC);

    state_t            state, state_nxt;
    logic [7:0]        cnt, cnt_nxt;
    logic              capture;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_dat;
    logic [DATA_W-1:0] mem [0:2**ADDR_W-1];

    // cnt holds samples already accepted; the current edge supplies one more.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = 8'd0;
                if (bus.prog && bus.wr_btn) begin
                    if (DB_LAST == 8'd1) begin
                        state_nxt = WRITE;
                        capture   = 1'b1;
                    end else begin
                        state_nxt = DEBOUNCE;
                        cnt_nxt   = 8'd1;
                    end
                end
            end
            DEBOUNCE: begin
                if (!bus.prog || !bus.wr_btn) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 8'd0;
                end else if (cnt + 8'd1 == DB_LAST) begin
                    state_nxt = WRITE;
                    cnt_nxt   = 8'd0;
                    capture   = 1'b1;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            WRITE: begin
                state_nxt = RELEASE;
                cnt_nxt   = 8'd0;
            end
            RELEASE: begin
                if (bus.wr_btn) begin
                    cnt_nxt = 8'd0;
                end else if (cnt + 8'd1 == DB_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 8'd0;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            wr_addr     <= '0;
            wr_dat      <= '0;
            bus.wr_busy <= 1'b0;
            bus.wr_done <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            bus.wr_busy <= (state_nxt == WRITE) || (state_nxt == RELEASE);
            bus.wr_done <= (state == WRITE);
            if (capture) begin
                wr_addr <= bus.addr;
                wr_dat  <= bus.sw_data;
            end
        end
    end

`ifdef SAP_RAM_CLEAR_EN
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 2**ADDR_W; i++) begin
                mem[i] <= '0;
            end
        end else if (state == WRITE) begin
            mem[wr_addr] <= wr_dat;
        end
    end
`else
    // Panel RAM keeps its contents through clr; clr only discards a pending write.
    always_ff @(posedge clk) begin
        if (!clr && state == WRITE) begin
            mem[wr_addr] <= wr_dat;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (clr || bus.prog || bus.ce_n) begin
            bus.bus_out <= '0;
            bus.bus_oe  <= 1'b0;
        end else begin
            bus.bus_out <= mem[bus.addr];
            bus.bus_oe  <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sap_ram16x8.sv
// Directed bench for sap_ram16x8: debounced writes, run-mode reads checked via an expected-data queue.
module tb_sap_ram16x8;
    localparam int DB = 4;

    logic clk = 1'b0;
    logic clr;
    int   checks = 0;
    int   failures = 0;
    logic [7:0] model [16];
    logic [7:0] exp_q [$];
    int   n_done, done_at, busy_seen;
    int   bp [$];

    sap_ram16x8_if #(.ADDR_W(4), .DATA_W(8)) ifc ();

    sap_ram16x8 #(.ADDR_W(4), .DATA_W(8), .DEBOUNCE_CYC(DB)) dut (
        .clk (clk),
        .clr (clr),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
`ifdef SAP_RAM_CLEAR_EN
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
`endif
    endtask

    // Holds a clean press for 'hold' edges; address/data switch to a2/d2 once WRITE is entered.
    task automatic press(input logic [3:0] a, input logic [7:0] d, input logic [3:0] a2,
                         input logic [7:0] d2, input int hold, output int nd, output int at);
        ifc.prog = 1'b1; ifc.ce_n = 1'b1;
        ifc.addr = a; ifc.sw_data = d; ifc.wr_btn = 1'b1;
        nd = 0; at = 0;
        for (int k = 1; k <= hold; k++) begin
            tick();
            if (ifc.wr_done) begin nd++; at = k; end
            if (k == DB - 1) chk("busy_before_write", 32'(ifc.wr_busy), 32'd0);
            if (k == DB) begin
                chk("busy_at_write", 32'(ifc.wr_busy), 32'd1);
                ifc.addr = a2; ifc.sw_data = d2;
            end
        end
    endtask

    task automatic release_btn();
        int nd;
        nd = 0;
        ifc.wr_btn = 1'b0;
        for (int k = 1; k <= DB; k++) begin
            tick();
            if (ifc.wr_done) nd++;
            if (k == DB - 1) chk("busy_in_release", 32'(ifc.wr_busy), 32'd1);
            if (k == DB) chk("busy_after_release", 32'(ifc.wr_busy), 32'd0);
        end
        chk("no_done_in_release", 32'(nd), 32'd0);
    endtask

    task automatic rd(input logic [3:0] a);
        ifc.prog = 1'b0; ifc.ce_n = 1'b0; ifc.addr = a; ifc.wr_btn = 1'b0;
        exp_q.push_back(model[a]);
        tick();
        chk("rd_oe", 32'(ifc.bus_oe), 32'd1);
        if (ifc.bus_oe) chk($sformatf("rd_dat[%0h]", a), 32'(ifc.bus_out), 32'(exp_q.pop_front()));
        ifc.ce_n = 1'b1;
    endtask

    initial begin
        clr = 1'b1;
        ifc.addr = 4'h0; ifc.prog = 1'b0; ifc.sw_data = 8'h00;
        ifc.wr_btn = 1'b0; ifc.ce_n = 1'b1;
        clear_model();
        tick(); tick();
        chk("rst_bus_out", 32'(ifc.bus_out), 32'd0);
        chk("rst_bus_oe", 32'(ifc.bus_oe), 32'd0);
        chk("rst_wr_busy", 32'(ifc.wr_busy), 32'd0);
        chk("rst_wr_done", 32'(ifc.wr_done), 32'd0);
        clr = 1'b0;
        tick();

        // Preload two locations used later as "unchanged" references.
        press(4'h7, 8'h3C, 4'h7, 8'h3C, 6, n_done, done_at); model[7] = 8'h3C;
        release_btn();
        press(4'h9, 8'h42, 4'h9, 8'h42, 6, n_done, done_at); model[9] = 8'h42;
        release_btn();

        // Clean press held for 10 cycles: one write, wr_done at cycle DB+1.
        press(4'h3, 8'hA5, 4'h3, 8'hA5, 10, n_done, done_at); model[3] = 8'hA5;
        chk("clean_done_count", 32'(n_done), 32'd1);
        chk("clean_done_cycle", 32'(done_at), 32'(DB + 1));
        release_btn();
        rd(4'h3);
        rd(4'h7);

        // Press bounce, hold, then release bounce: single write after the last four highs.
        bp = '{1,0,1,1,0,1,1,1,1,1,1,1,1,1, 0,1,0,0,0,0,0,0};
        ifc.prog = 1'b1; ifc.addr = 4'h5; ifc.sw_data = 8'h5A;
        n_done = 0; done_at = 0;
        foreach (bp[i]) begin
            ifc.wr_btn = bp[i][0];
            tick();
            if (ifc.wr_done) begin n_done++; done_at = i + 1; end
        end
        model[5] = 8'h5A;
        chk("bounce_done_count", 32'(n_done), 32'd1);
        chk("bounce_done_cycle", 32'd10, 32'(done_at));
        chk("bounce_idle_busy", 32'(ifc.wr_busy), 32'd0);
        rd(4'h5);

        // prog drops after two debounce samples: aborted, no write.
        ifc.prog = 1'b1; ifc.addr = 4'h9; ifc.sw_data = 8'h99; ifc.wr_btn = 1'b1;
        n_done = 0; busy_seen = 0;
        tick(); tick();
        ifc.prog = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (ifc.wr_done) n_done++;
            if (ifc.wr_busy) busy_seen++;
        end
        ifc.wr_btn = 1'b0;
        tick();
        chk("abort_no_done", 32'(n_done), 32'd0);
        chk("abort_no_busy", 32'(busy_seen), 32'd0);
        rd(4'h9);
        // FSM must be back in IDLE: a fresh press writes with nominal timing.
        press(4'h9, 8'h24, 4'h9, 8'h24, 6, n_done, done_at); model[9] = 8'h24;
        chk("after_abort_done_cycle", 32'(done_at), 32'(DB + 1));
        release_btn();
        rd(4'h9);

        // Address/data change after WRITE entry must not affect the stored word.
        press(4'h3, 8'hA5, 4'h7, 8'hFF, 8, n_done, done_at);
        chk("latch_done_count", 32'(n_done), 32'd1);
        release_btn();
        rd(4'h3);
        rd(4'h7);

        // clr while in RELEASE.
        press(4'h3, 8'hA5, 4'h3, 8'hA5, 6, n_done, done_at);
        clr = 1'b1; ifc.wr_btn = 1'b0;
        tick();
        clear_model();
        chk("clr_bus_out", 32'(ifc.bus_out), 32'd0);
        chk("clr_bus_oe", 32'(ifc.bus_oe), 32'd0);
        chk("clr_wr_busy", 32'(ifc.wr_busy), 32'd0);
        chk("clr_wr_done", 32'(ifc.wr_done), 32'd0);
        clr = 1'b0;
        tick();
        rd(4'h3);

        // clr coinciding with the WRITE exit edge discards the write.
        press(4'h9, 8'h77, 4'h9, 8'h77, DB, n_done, done_at);
        clr = 1'b1; ifc.wr_btn = 1'b0;
        tick();
        clear_model();
        chk("clr_write_done", 32'(ifc.wr_done), 32'd0);
        clr = 1'b0;
        tick();
        chk("clr_write_no_late_done", 32'(ifc.wr_done), 32'd0);
        rd(4'h9);

        // Bus enable gating.
        ifc.prog = 1'b0; ifc.ce_n = 1'b1; ifc.addr = 4'h5;
        tick();
        chk("ce_off_oe", 32'(ifc.bus_oe), 32'd0);
        chk("ce_off_out", 32'(ifc.bus_out), 32'd0);
        ifc.prog = 1'b1; ifc.ce_n = 1'b0;
        tick();
        chk("prog_read_oe", 32'(ifc.bus_oe), 32'd0);
        chk("prog_read_out", 32'(ifc.bus_out), 32'd0);
        ifc.ce_n = 1'b1; ifc.prog = 1'b0;
        tick();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sap_ram16x8.md
# sap_ram16x8

16×8 program/data RAM for the SAP-1 datapath, sitting directly downstream of the 2:1 address multiplexer (ci157). It takes the 4-bit address selected by the mux (manual switches in program mode, MAR in run mode). It stores bytes entered from the front-panel data switches through a debounced manual write button. In run mode it drives the addressed byte onto the W bus when enabled by the controller.

## Interface
- `ADDR_W`, 4: address width; depth is 2**ADDR_W.
- `DATA_W`, 8: word width.
- `DEBOUNCE_CYC`, 4: consecutive stable samples needed on `wr_btn` to accept a press or a release; legal range 1..255.

- `clk` in 1: single system clock, rising edge.
- `clr` in 1: reset, synchronous, active-high.
- `addr` in ADDR_W: address from the mux output `S`.
- `prog` in 1: 1 = program mode, 0 = run mode.
- `sw_data` in DATA_W: front-panel data switches.
- `wr_btn` in 1: raw manual write button, active-high, may bounce.
- `ce_n` in 1: controller RAM-to-bus enable, active-low. Honoured only in run mode.
- `bus_out` out DATA_W: registered read data for the W bus.
- `bus_oe` out 1: `bus_out` is valid and driving.
- `wr_busy` out 1: a write/release sequence is in progress.
- `wr_done` out 1: one-cycle pulse after a memory write.

## Operation
- Storage is `mem[0:2**ADDR_W-1]` of DATA_W bits. `clr` does not alter contents unless the macro below is defined.
- Read path, active only when `prog`=0:
  - At each edge, if `ce_n`=0: `bus_out` <= `mem[addr]` and `bus_oe` <= 1.
  - Otherwise `bus_out` <= 0 and `bus_oe` <= 0.
  - When `prog`=1, `bus_oe`=0 and `bus_out`=0 regardless of `ce_n`.
- Write FSM states: IDLE, DEBOUNCE, WRITE, RELEASE.
  - IDLE: counter = 0. If `prog`=1 and `wr_btn`=1, go to DEBOUNCE with counter = 1.
  - DEBOUNCE:
    - `wr_btn`=0 → IDLE.
    - `wr_btn`=1 and counter = DEBOUNCE_CYC → WRITE, latching `addr` and `sw_data` at this edge.
    - Otherwise counter increments.
  - WRITE: lasts exactly one cycle. At its exit edge, the latched address receives the latched data, `wr_done` is set, and the FSM goes to RELEASE.
  - RELEASE: counts consecutive `wr_btn`=0 samples; any 1 sample resets the count. After DEBOUNCE_CYC low samples, go to IDLE.
    - Each press therefore produces exactly one write, regardless of bounce or hold time.
- `wr_busy` = 1 in WRITE and RELEASE.
- `prog` falling to 0:
  - In DEBOUNCE, aborts to IDLE with no write.
  - In WRITE, the write still completes.
  - In RELEASE, the release wait continues.
- Changes to `addr` or `sw_data` after the WRITE entry edge do not affect the stored word.
- Reads and writes are mutually exclusive by mode. If a WRITE completes in the same cycle a run-mode read samples the same address, the read returns the old data.

## Timing
- Reset values after a `clr` edge:
  - `bus_out`=0, `bus_oe`=0, `wr_busy`=0, `wr_done`=0.
  - FSM = IDLE, counters = 0.
- `clr` mid-sequence (any state) returns to IDLE with no write. If `clr` and the WRITE exit edge coincide, `clr` wins and the write is discarded.
- Read latency is 1 cycle: `ce_n`=0 and `addr`=A sampled at edge N gives `mem[A]` on `bus_out` after edge N.
- Write latency, from the first high `wr_btn` sample at edge 1:
  - WRITE is entered at edge DEBOUNCE_CYC.
  - Memory updates at edge DEBOUNCE_CYC+1.
  - `wr_done` is high for the single cycle after that edge.
- A new press is accepted only after RELEASE completes. The minimum spacing between writes is 2·DEBOUNCE_CYC+1 cycles.
- All outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- `SAP_RAM_CLEAR_EN`:
  - Defined: a `clr` edge also zeroes every memory word in that same edge.
  - Undefined: memory retains its contents through `clr`, like the SAP-1 panel RAM. Contents are X until written.

## Test plan
- Program mode, `addr`=4'h3, `sw_data`=8'hA5, clean `wr_btn` high for 10 cycles → `wr_done` pulses once at cycle 5 (DEBOUNCE_CYC=4). Then in run mode, `addr`=3 with `ce_n`=0 → `bus_out`=8'hA5 and `bus_oe`=1 one cycle later.
- Bouncing `wr_btn` (1,0,1,1,0,1,1,1,1, then held) → exactly one write, after the final 4 consecutive highs. Bounce on release (0,1,0,0,0,0) → no second write.
- `addr` changes 3→7 and `sw_data` A5→FF during RELEASE → `mem[3]`=A5 and `mem[7]` is unchanged.
- `prog` drops after 2 debounce samples → no write, `wr_busy` stays 0, and the FSM is in IDLE.
- `clr` asserted in RELEASE → all outputs are 0 next cycle. `mem[3]` keeps A5 without `SAP_RAM_CLEAR_EN`, and reads 8'h00 with it.
- Run mode with `ce_n`=1 → `bus_oe`=0 and `bus_out`=0. In program mode with `ce_n`=0 → `bus_oe` stays 0.
